// File: rtl/snitch_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snitch_icache_pkg
//  Description : Shared configuration record and pending-refill entry type
//                for the instruction-cache miss path.
//  Contents    : config_t        - cache geometry and miss-table sizing
//                c_DEFAULT_CFG   - 32-bit fetch, 16-byte lines, 32 lines,
//                                  4 sets, 2 pending refills, 4 requesters
//                pending_entry_t - {valid, line address, requester mask}
//  Revision    : 1.0 - initial release
// ============================================================================
package snitch_icache_pkg;

    // Upper bounds for the fields held in a pending entry. The entry type is
    // shared by every configuration, so each instance uses only the low
    // bits it needs.
    localparam int unsigned MAX_FETCH_AW = 64;
    localparam int unsigned MAX_ID_WIDTH = 32;

    typedef struct packed {
        int unsigned FETCH_AW;       // fetch address width
        int unsigned ID_WIDTH_REQ;   // one-hot requester mask width
        int unsigned LINE_WIDTH;     // cache line width in bits
        int unsigned LINE_ALIGN;     // log2 of line size in bytes
        int unsigned COUNT_ALIGN;    // log2 of lines per set
        int unsigned SET_COUNT;      // number of ways
        int unsigned SET_ALIGN;      // log2 of SET_COUNT
        int unsigned TAG_WIDTH;      // FETCH_AW - LINE_ALIGN - COUNT_ALIGN
        int unsigned PENDING_COUNT;  // outstanding refill slots
        int unsigned PENDING_IW;     // clog2(PENDING_COUNT)
    } config_t;

    localparam config_t c_DEFAULT_CFG = '{
        FETCH_AW:      32,
        ID_WIDTH_REQ:  4,
        LINE_WIDTH:    128,
        LINE_ALIGN:    4,
        COUNT_ALIGN:   5,
        SET_COUNT:     4,
        SET_ALIGN:     2,
        TAG_WIDTH:     23,
        PENDING_COUNT: 2,
        PENDING_IW:    1
    };

    // addr holds the line address (fetch address >> LINE_ALIGN).
    typedef struct packed {
        logic                    valid;
        logic [MAX_FETCH_AW-1:0] addr;
        logic [MAX_ID_WIDTH-1:0] idmask;
    } pending_entry_t;

endpackage
`default_nettype wire

// File: rtl/snitch_icache_pending_table.sv
`default_nettype none
// ============================================================================
//  Module      : snitch_icache_pending_table
//  Description : Table of outstanding line refills. Each entry records the
//                line being fetched and the requesters waiting on it.
//  Ports       : clk_i/rst_ni             clock, synchronous active-low reset
//                lookup_line_i            line address to search for
//                match_o/match_idx_o      valid entry holding that line
//                full_o/free_idx_o        all slots busy / lowest free slot
//                set_*                    allocate a slot {line, id}
//                merge_*                  OR a requester into a slot's mask
//                clear_*                  release a slot
//                read_idx_i/read_*_o      contents of one slot
//  Revision    : 1.0 - initial release
// ============================================================================
module snitch_icache_pending_table
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = c_DEFAULT_CFG
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0]  lookup_line_i,
    output logic                                    match_o,
    output logic [CFG.PENDING_IW-1:0]               match_idx_o,
    output logic                                    full_o,
    output logic [CFG.PENDING_IW-1:0]               free_idx_o,
    input  logic                                    set_i,
    input  logic [CFG.PENDING_IW-1:0]               set_idx_i,
    input  logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0]  set_line_i,
    input  logic [CFG.ID_WIDTH_REQ-1:0]             set_id_i,
    input  logic                                    merge_i,
    input  logic [CFG.PENDING_IW-1:0]               merge_idx_i,
    input  logic [CFG.ID_WIDTH_REQ-1:0]             merge_id_i,
    input  logic                                    clear_i,
    input  logic [CFG.PENDING_IW-1:0]               clear_idx_i,
    input  logic [CFG.PENDING_IW-1:0]               read_idx_i,
    output logic                                    read_valid_o,
    output logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0]  read_line_o,
    output logic [CFG.ID_WIDTH_REQ-1:0]             read_id_o
);

    localparam int unsigned c_LINE_AW = CFG.FETCH_AW - CFG.LINE_ALIGN;
    localparam int unsigned c_COUNT   = CFG.PENDING_COUNT;
    localparam int unsigned c_IW      = CFG.PENDING_IW;
    localparam int unsigned c_IDW     = CFG.ID_WIDTH_REQ;

    pending_entry_t r_entries [c_COUNT];

    logic [c_COUNT-1:0] w_valid;
    logic               w_unused_hi;

    // Line search. A line is allocated only when it is not already pending,
    // so at most one entry can match.
    always_comb begin
        match_o     = 1'b0;
        match_idx_o = '0;
        w_valid     = '0;
        for (int i = 0; i < c_COUNT; i++) begin
            w_valid[i] = r_entries[i].valid;
            if (r_entries[i].valid && (r_entries[i].addr[c_LINE_AW-1:0] == lookup_line_i)) begin
                match_o     = 1'b1;
                match_idx_o = c_IW'(i);
            end
        end
    end

    // Trailing-zero count over the free vector: scanning from the top down
    // leaves the lowest invalid index.
    always_comb begin
        free_idx_o = '0;
        for (int i = c_COUNT - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                free_idx_o = c_IW'(i);
            end
        end
    end

    assign full_o = &w_valid;

    assign read_valid_o = r_entries[read_idx_i].valid;
    assign read_line_o  = r_entries[read_idx_i].addr[c_LINE_AW-1:0];
    assign read_id_o    = r_entries[read_idx_i].idmask[c_IDW-1:0];

    // Upper bits of the shared entry type are never populated here.
    always_comb begin
        w_unused_hi = 1'b0;
        for (int i = 0; i < c_COUNT; i++) begin
            w_unused_hi = w_unused_hi ^ (^r_entries[i].addr[MAX_FETCH_AW-1:c_LINE_AW])
                                      ^ (^r_entries[i].idmask[MAX_ID_WIDTH-1:c_IDW]);
        end
    end

    // set, merge and clear always address different slots: set targets a
    // free slot, clear a completing one, merge a pending non-completing one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < c_COUNT; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_COUNT; i++) begin
                if (clear_i && (clear_idx_i == c_IW'(i))) begin
                    r_entries[i].valid <= 1'b0;
                end
                if (set_i && (set_idx_i == c_IW'(i))) begin
                    r_entries[i].valid  <= 1'b1;
                    r_entries[i].addr   <= MAX_FETCH_AW'(set_line_i);
                    r_entries[i].idmask <= MAX_ID_WIDTH'(set_id_i);
                end
                if (merge_i && (merge_idx_i == c_IW'(i))) begin
                    r_entries[i].idmask <= r_entries[i].idmask | MAX_ID_WIDTH'(merge_id_i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snitch_icache_miss_handler.sv
`default_nettype none
// ============================================================================
//  Module      : snitch_icache_miss_handler
//  Description : Post-lookup stage of the instruction cache. Hits are
//                answered combinationally; misses either join a pending
//                refill of the same line or allocate a new refill. Returning
//                lines are written into the cache and answered to every
//                merged requester in the same cycle.
//  Ports       : clk_i/rst_ni          clock, synchronous active-low reset
//                in_*                  lookup result (valid/ready)
//                rsp_*                 core response (valid/ready)
//                refill_req_*          line refill request (valid/ready)
//                refill_rsp_*          line refill return (valid/ready)
//                write_*               lookup-stage write port (valid/ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module snitch_icache_miss_handler
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = c_DEFAULT_CFG
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic [CFG.FETCH_AW-1:0]      in_addr_i,
    input  logic [CFG.ID_WIDTH_REQ-1:0]  in_id_i,
    input  logic [CFG.SET_ALIGN-1:0]     in_set_i,
    input  logic                         in_hit_i,
    input  logic [CFG.LINE_WIDTH-1:0]    in_data_i,
    input  logic                         in_error_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,

    output logic [CFG.FETCH_AW-1:0]      rsp_addr_o,
    output logic [CFG.ID_WIDTH_REQ-1:0]  rsp_id_o,
    output logic [CFG.LINE_WIDTH-1:0]    rsp_data_o,
    output logic                         rsp_error_o,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,

    output logic [CFG.FETCH_AW-1:0]      refill_req_addr_o,
    output logic [CFG.PENDING_IW-1:0]    refill_req_id_o,
    output logic                         refill_req_valid_o,
    input  logic                         refill_req_ready_i,

    input  logic [CFG.LINE_WIDTH-1:0]    refill_rsp_data_i,
    input  logic                         refill_rsp_error_i,
    input  logic [CFG.PENDING_IW-1:0]    refill_rsp_id_i,
    input  logic                         refill_rsp_valid_i,
    output logic                         refill_rsp_ready_o,

    output logic [CFG.COUNT_ALIGN-1:0]   write_addr_o,
    output logic [CFG.SET_ALIGN-1:0]     write_set_o,
    output logic [CFG.LINE_WIDTH-1:0]    write_data_o,
    output logic [CFG.TAG_WIDTH-1:0]     write_tag_o,
    output logic                         write_error_o,
    output logic                         write_valid_o,
    input  logic                         write_ready_i
);

    localparam int unsigned c_LINE_AW = CFG.FETCH_AW - CFG.LINE_ALIGN;
    localparam int unsigned c_SET_AW  = CFG.SET_ALIGN;
    localparam int unsigned c_TAG_W   = CFG.TAG_WIDTH;
    localparam int unsigned c_CNT_W   = CFG.COUNT_ALIGN;
    localparam int unsigned c_IW      = CFG.PENDING_IW;

    logic [c_LINE_AW-1:0]        w_line;
    logic                        w_match;
    logic [c_IW-1:0]             w_match_idx;
    logic                        w_full;
    logic [c_IW-1:0]             w_free_idx;
    logic                        w_rd_valid;
    logic [c_LINE_AW-1:0]        w_rd_line;
    logic [CFG.ID_WIDTH_REQ-1:0] w_rd_id;

    logic                        w_rsp_fire;
    logic                        w_is_miss;
    logic                        w_same_line;
    logic                        w_merge;
    logic                        w_alloc_req;
    logic                        w_unused_set;

    logic [c_SET_AW-1:0]         r_victim;

    assign w_line       = in_addr_i[CFG.FETCH_AW-1:CFG.LINE_ALIGN];
    assign w_unused_set = ^in_set_i;

    snitch_icache_pending_table #(
        .CFG (CFG)
    ) u_pending_table (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lookup_line_i (w_line),
        .match_o       (w_match),
        .match_idx_o   (w_match_idx),
        .full_o        (w_full),
        .free_idx_o    (w_free_idx),
        .set_i         (w_alloc_req && refill_req_ready_i),
        .set_idx_i     (w_free_idx),
        .set_line_i    (w_line),
        .set_id_i      (in_id_i),
        .merge_i       (w_merge),
        .merge_idx_i   (w_match_idx),
        .merge_id_i    (in_id_i),
        .clear_i       (w_rsp_fire),
        .clear_idx_i   (refill_rsp_id_i),
        .read_idx_i    (refill_rsp_id_i),
        .read_valid_o  (w_rd_valid),
        .read_line_o   (w_rd_line),
        .read_id_o     (w_rd_id)
    );

    // A refill return needs both the write port and the response port in the
    // same cycle, so it is only accepted when both are ready.
    assign refill_rsp_ready_o = rst_ni && write_ready_i && rsp_ready_i;
    assign w_rsp_fire         = refill_rsp_valid_i && refill_rsp_ready_o;

    assign w_is_miss   = rst_ni && in_valid_i && !in_hit_i;
    // A miss on the line being returned this cycle rides on that response
    // instead of merging into an entry that is about to be released.
    assign w_same_line = w_is_miss && w_match && w_rsp_fire && (w_match_idx == refill_rsp_id_i);
    assign w_merge     = w_is_miss && w_match && !w_same_line;
    assign w_alloc_req = w_is_miss && !w_match && !w_full;

    always_comb begin
        in_ready_o = 1'b0;
        if (rst_ni) begin
            if (in_hit_i) begin
                in_ready_o = !w_rsp_fire && rsp_ready_i;
            end else if (w_match) begin
                in_ready_o = 1'b1;
            end else if (!w_full) begin
                in_ready_o = refill_req_ready_i;
            end
        end
    end

    // Refill completions own the response port; hits use it otherwise.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_addr_o  = in_addr_i;
        rsp_id_o    = in_id_i;
        rsp_data_o  = in_data_i;
        rsp_error_o = in_error_i;
        if (w_rsp_fire) begin
            rsp_valid_o = 1'b1;
            rsp_addr_o  = {w_rd_line, {CFG.LINE_ALIGN{1'b0}}};
            rsp_id_o    = w_rd_id | (w_same_line ? in_id_i : '0);
            rsp_data_o  = refill_rsp_data_i;
            rsp_error_o = refill_rsp_error_i;
        end else begin
            rsp_valid_o = rst_ni && in_valid_i && in_hit_i;
        end
    end

    assign refill_req_valid_o = w_alloc_req;
    assign refill_req_addr_o  = {w_line, {CFG.LINE_ALIGN{1'b0}}};
    assign refill_req_id_o    = w_free_idx;

    assign write_valid_o = w_rsp_fire;
    assign write_addr_o  = w_rd_line[c_CNT_W-1:0];
    assign write_tag_o   = c_TAG_W'(w_rd_line >> c_CNT_W);
    assign write_set_o   = r_victim;
    assign write_data_o  = refill_rsp_data_i;
    assign write_error_o = refill_rsp_error_i;

    // Round-robin victim selection across the sets.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_victim <= '0;
        end else if (w_rsp_fire) begin
            if (r_victim == c_SET_AW'(CFG.SET_COUNT - 1)) begin
                r_victim <= '0;
            end else begin
                r_victim <= r_victim + c_SET_AW'(1);
            end
        end
    end

    // A refill may only return for a slot that is waiting for it.
    a_refill_rsp_pending: assert property (
        @(posedge clk_i) disable iff (!rst_ni) refill_rsp_valid_i |-> w_rd_valid
    );

endmodule
`default_nettype wire

// File: tb/tb_snitch_icache_miss_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snitch_icache_miss_handler
//  Description : Directed scenarios followed by random traffic, each cycle
//                checked against a table-of-refills reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snitch_icache_miss_handler;
    import snitch_icache_pkg::*;

    localparam config_t CFG = '{
        FETCH_AW: 32, ID_WIDTH_REQ: 4, LINE_WIDTH: 128, LINE_ALIGN: 4, COUNT_ALIGN: 5,
        SET_COUNT: 4, SET_ALIGN: 2, TAG_WIDTH: 23, PENDING_COUNT: 2, PENDING_IW: 1
    };

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [31:0]  in_addr_i;
    logic [3:0]   in_id_i;
    logic [1:0]   in_set_i;
    logic         in_hit_i;
    logic [127:0] in_data_i;
    logic         in_error_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  rsp_addr_o;
    logic [3:0]   rsp_id_o;
    logic [127:0] rsp_data_o;
    logic         rsp_error_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  refill_req_addr_o;
    logic [0:0]   refill_req_id_o;
    logic         refill_req_valid_o;
    logic         refill_req_ready_i;
    logic [127:0] refill_rsp_data_i;
    logic         refill_rsp_error_i;
    logic [0:0]   refill_rsp_id_i;
    logic         refill_rsp_valid_i;
    logic         refill_rsp_ready_o;
    logic [4:0]   write_addr_o;
    logic [1:0]   write_set_o;
    logic [127:0] write_data_o;
    logic [22:0]  write_tag_o;
    logic         write_error_o;
    logic         write_valid_o;
    logic         write_ready_i;

    always #5 clk_i = ~clk_i;

    snitch_icache_miss_handler #(.CFG(CFG)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .in_addr_i          (in_addr_i),
        .in_id_i            (in_id_i),
        .in_set_i           (in_set_i),
        .in_hit_i           (in_hit_i),
        .in_data_i          (in_data_i),
        .in_error_i         (in_error_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .rsp_addr_o         (rsp_addr_o),
        .rsp_id_o           (rsp_id_o),
        .rsp_data_o         (rsp_data_o),
        .rsp_error_o        (rsp_error_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .refill_req_addr_o  (refill_req_addr_o),
        .refill_req_id_o    (refill_req_id_o),
        .refill_req_valid_o (refill_req_valid_o),
        .refill_req_ready_i (refill_req_ready_i),
        .refill_rsp_data_i  (refill_rsp_data_i),
        .refill_rsp_error_i (refill_rsp_error_i),
        .refill_rsp_id_i    (refill_rsp_id_i),
        .refill_rsp_valid_i (refill_rsp_valid_i),
        .refill_rsp_ready_o (refill_rsp_ready_o),
        .write_addr_o       (write_addr_o),
        .write_set_o        (write_set_o),
        .write_data_o       (write_data_o),
        .write_tag_o        (write_tag_o),
        .write_error_o      (write_error_o),
        .write_valid_o      (write_valid_o),
        .write_ready_i      (write_ready_i)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the set of lines being fetched and who waits on each.
    bit          m_v    [2];
    logic [27:0] m_line [2];
    logic [3:0]  m_mask [2];
    int          m_victim;

    // Expected outputs for the current cycle.
    bit           e_fire, e_match, e_full, e_in_ready, e_rsp_valid, e_req_valid, e_rsp_err;
    int           e_midx, e_free;
    logic [31:0]  e_rsp_addr;
    logic [3:0]   e_rsp_id;
    logic [127:0] e_rsp_data;

    // Observed values latched at the last check point.
    logic [3:0]   obs_rsp_id;
    logic         obs_in_ready, obs_req_valid, obs_rsp_valid;
    logic [31:0]  obs_req_addr;
    logic [0:0]   obs_req_id;
    logic [1:0]   obs_wset;
    logic [4:0]   obs_waddr;
    logic [22:0]  obs_wtag;
    logic [127:0] obs_rsp_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [27:0] line;
        int          slot;
        line    = in_addr_i[31:4];
        e_fire  = refill_rsp_valid_i && write_ready_i && rsp_ready_i;
        e_match = 0; e_midx = 0; e_full = 1; e_free = -1;
        for (int i = 0; i < 2; i++) begin
            if (m_v[i] && m_line[i] == line) begin e_match = 1; e_midx = i; end
            if (!m_v[i]) begin
                e_full = 0;
                if (e_free < 0) e_free = i;
            end
        end
        if (e_fire) begin
            slot        = int'(refill_rsp_id_i);
            e_rsp_valid = 1;
            e_rsp_addr  = {m_line[slot], 4'h0};
            e_rsp_id    = m_mask[slot];
            if (in_valid_i && !in_hit_i && e_match && e_midx == slot) e_rsp_id = e_rsp_id | in_id_i;
            e_rsp_data  = refill_rsp_data_i;
            e_rsp_err   = refill_rsp_error_i;
        end else begin
            e_rsp_valid = in_valid_i && in_hit_i;
            e_rsp_addr  = in_addr_i;
            e_rsp_id    = in_id_i;
            e_rsp_data  = in_data_i;
            e_rsp_err   = in_error_i;
        end
        if (in_hit_i)      e_in_ready = !e_fire && rsp_ready_i;
        else if (e_match)  e_in_ready = 1;
        else if (!e_full)  e_in_ready = refill_req_ready_i;
        else               e_in_ready = 0;
        e_req_valid = in_valid_i && !in_hit_i && !e_match && !e_full;
    endtask

    task automatic model_update();
        int slot;
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) m_v[i] = 0;
            m_victim = 0;
            return;
        end
        slot = int'(refill_rsp_id_i);
        if (e_fire) begin
            m_v[slot] = 0;
            m_victim  = (m_victim + 1) % 4;
        end
        if (in_valid_i && !in_hit_i && e_in_ready) begin
            if (e_match) begin
                if (!(e_fire && e_midx == slot)) m_mask[e_midx] = m_mask[e_midx] | in_id_i;
            end else begin
                m_v[e_free]    = 1;
                m_line[e_free] = in_addr_i[31:4];
                m_mask[e_free] = in_id_i;
            end
        end
    endtask

    // One clock: check at the falling edge, then advance model and DUT.
    task automatic step(input string lbl);
        @(negedge clk_i);
        if (!rst_ni) begin
            chk({lbl, "/rst_in_ready"},  in_ready_o, 0);
            chk({lbl, "/rst_rsp_valid"}, rsp_valid_o, 0);
            chk({lbl, "/rst_req_valid"}, refill_req_valid_o, 0);
            chk({lbl, "/rst_rr_ready"},  refill_rsp_ready_o, 0);
            chk({lbl, "/rst_wr_valid"},  write_valid_o, 0);
        end else begin
            model_eval();
            chk({lbl, "/rr_ready"}, refill_rsp_ready_o, write_ready_i && rsp_ready_i);
            chk({lbl, "/rsp_valid"}, rsp_valid_o, e_rsp_valid);
            if (e_rsp_valid) begin
                chk({lbl, "/rsp_addr"}, rsp_addr_o, e_rsp_addr);
                chk({lbl, "/rsp_id"},   rsp_id_o,   e_rsp_id);
                chk({lbl, "/rsp_data"}, rsp_data_o, e_rsp_data);
                chk({lbl, "/rsp_err"},  rsp_error_o, e_rsp_err);
            end
            chk({lbl, "/wr_valid"}, write_valid_o, e_fire);
            if (e_fire) begin
                chk({lbl, "/wr_addr"}, write_addr_o, m_line[int'(refill_rsp_id_i)] % 32);
                chk({lbl, "/wr_tag"},  write_tag_o,  m_line[int'(refill_rsp_id_i)] / 32);
                chk({lbl, "/wr_set"},  write_set_o,  m_victim);
                chk({lbl, "/wr_data"}, write_data_o, refill_rsp_data_i);
                chk({lbl, "/wr_err"},  write_error_o, refill_rsp_error_i);
            end
            chk({lbl, "/req_valid"}, refill_req_valid_o, e_req_valid);
            if (e_req_valid) begin
                chk({lbl, "/req_addr"}, refill_req_addr_o, {in_addr_i[31:4], 4'h0});
                chk({lbl, "/req_id"},   refill_req_id_o, e_free);
            end
            if (in_valid_i) chk({lbl, "/in_ready"}, in_ready_o, e_in_ready);
        end
        obs_rsp_id    = rsp_id_o;
        obs_rsp_data  = rsp_data_o;
        obs_rsp_valid = rsp_valid_o;
        obs_in_ready  = in_ready_o;
        obs_req_valid = refill_req_valid_o;
        obs_req_addr  = refill_req_addr_o;
        obs_req_id    = refill_req_id_o;
        obs_wset      = write_set_o;
        obs_waddr     = write_addr_o;
        obs_wtag      = write_tag_o;
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic set_in(input bit v, input bit hit, input logic [31:0] a, input logic [3:0] id);
        in_valid_i = v;
        in_hit_i   = hit;
        in_addr_i  = a;
        in_id_i    = id;
        in_data_i  = {$urandom, $urandom, $urandom, $urandom};
        in_error_i = 1'($urandom_range(0, 1));
        in_set_i   = 2'($urandom_range(0, 3));
    endtask

    task automatic set_rr(input bit v, input int id);
        refill_rsp_valid_i = v;
        refill_rsp_id_i    = 1'(id);
        refill_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        refill_rsp_error_i = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] hit_data;
        logic [1:0]   sets [5];
        int           pick [$];

        rst_ni = 1'b0;
        rsp_ready_i = 1; write_ready_i = 1; refill_req_ready_i = 1;
        set_in(1, 1, 32'h1000, 4'b0001);
        set_rr(0, 0);
        for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_line[i] = '0; m_mask[i] = '0; end
        m_victim = 0;
        @(posedge clk_i); #1;

        // Reset: every valid/ready held low even with a lookup presented.
        step("reset0");
        step("reset1");
        rst_ni = 1'b1;

        // 1: hit answered in the same cycle.
        set_in(1, 1, 32'h1000, 4'b0001);
        hit_data = in_data_i;
        step("t1_hit");
        chk("t1_rsp_id", obs_rsp_id, 4'b0001);
        chk("t1_rsp_data", obs_rsp_data, hit_data);
        chk("t1_no_req", obs_req_valid, 0);

        // 2: miss allocates slot 0, refill writes the line back.
        set_in(1, 0, 32'h2004, 4'b0010);
        step("t2_miss");
        chk("t2_req_addr", obs_req_addr, 32'h2000);
        chk("t2_req_id", obs_req_id, 0);
        set_in(0, 0, 0, 0);
        set_rr(1, 0);
        step("t2_done");
        chk("t2_waddr", obs_waddr, 0);
        chk("t2_wtag", obs_wtag, 23'h10);
        chk("t2_wset", obs_wset, 0);
        chk("t2_rsp_id", obs_rsp_id, 4'b0010);
        set_rr(0, 0);

        // 3: second miss to the pending line merges.
        set_in(1, 0, 32'h2004, 4'b0010);
        step("t3_alloc");
        set_in(1, 0, 32'h2008, 4'b0100);
        step("t3_merge");
        chk("t3_no_req", obs_req_valid, 0);
        chk("t3_in_ready", obs_in_ready, 1);
        set_in(0, 0, 0, 0);
        set_rr(1, 0);
        step("t3_done");
        chk("t3_rsp_id", obs_rsp_id, 4'b0110);
        set_rr(0, 0);

        // 4: table full stalls a new miss until a slot frees.
        set_in(1, 0, 32'h3000, 4'b0001); step("t4_a");
        set_in(1, 0, 32'h4000, 4'b0010); step("t4_b");
        set_in(1, 0, 32'h5000, 4'b0100); step("t4_stall0");
        chk("t4_stall", obs_in_ready, 0);
        step("t4_stall1");
        set_rr(1, 1);
        step("t4_free");
        chk("t4_stall_on_free", obs_in_ready, 0);
        set_rr(0, 0);
        step("t4_alloc");
        chk("t4_req_valid", obs_req_valid, 1);
        chk("t4_req_id", obs_req_id, 1);
        set_in(0, 0, 0, 0);
        set_rr(1, 0); step("t4_done0");
        set_rr(1, 1); step("t4_done1");
        set_rr(0, 0);

        // 5: completion pre-empts a hit; same-line miss joins the response.
        set_in(1, 0, 32'h2000, 4'b0001); step("t5_alloc");
        set_in(1, 1, 32'h1230, 4'b0010);
        set_rr(1, 0);
        step("t5_hit_stall");
        chk("t5_stall", obs_in_ready, 0);
        chk("t5_fill_id", obs_rsp_id, 4'b0001);
        set_rr(0, 0);
        step("t5_hit_go");
        chk("t5_hit_ready", obs_in_ready, 1);
        chk("t5_hit_id", obs_rsp_id, 4'b0010);
        set_in(1, 0, 32'h2000, 4'b0010); step("t5_alloc2");
        set_in(1, 0, 32'h2000, 4'b1000);
        set_rr(1, 0);
        step("t5_join");
        chk("t5_join_id", obs_rsp_id, 4'b1010);
        chk("t5_join_ready", obs_in_ready, 1);
        set_in(0, 0, 0, 0);
        set_rr(0, 0);

        // 6: victim sequence from reset, then reset drops the table.
        rst_ni = 1'b0; step("t6_rst"); rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(1, 0, 32'h6000 + 32'(k * 16), 4'b0001); step("t6_alloc");
            set_in(0, 0, 0, 0);
            set_rr(1, 0); step("t6_done");
            sets[k] = obs_wset;
            set_rr(0, 0);
        end
        chk("t6_set0", sets[0], 0);
        chk("t6_set1", sets[1], 1);
        chk("t6_set2", sets[2], 2);
        chk("t6_set3", sets[3], 3);
        chk("t6_set4", sets[4], 0);
        set_in(1, 0, 32'h7000, 4'b0001); step("t6_pend");
        rst_ni = 1'b0;
        set_in(1, 0, 32'h7000, 4'b0010);
        step("t6_midrst");
        rst_ni = 1'b1;
        step("t6_after");
        chk("t6_realloc", obs_req_valid, 1);
        chk("t6_realloc_id", obs_req_id, 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit hit;
            rsp_ready_i        = ($urandom_range(0, 3) != 0);
            write_ready_i      = ($urandom_range(0, 3) != 0);
            refill_req_ready_i = ($urandom_range(0, 3) != 0);
            hit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                if (hit) set_in(1, 1, $urandom, 4'(1 << $urandom_range(0, 3)));
                else     set_in(1, 0, 32'h1000 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 15)),
                                4'(1 << $urandom_range(0, 3)));
            end else begin
                set_in(0, 0, $urandom, 4'b0001);
            end
            pick.delete();
            for (int i = 0; i < 2; i++) if (m_v[i]) pick.push_back(i);
            if (pick.size() > 0 && $urandom_range(0, 1) == 1)
                set_rr(1, pick[$urandom_range(0, pick.size() - 1)]);
            else
                set_rr(0, 0);
            rst_ni = (n != 300);
            step("rand");
        end
        rst_ni = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
